dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory port.
- Accepts one load/store request at a time from the core over a valid/ready request channel.
- Performs byte-masked writes and word reads on an internal word array after a programmable access latency.
- Returns the result over a valid/ready response channel.
- Sits between the mips core's data port and the data storage; replaces the zero-wait direct RAM hookup so the core can be tested against a slow memory.

Parameters:
- ADDR_W, 10, word-index width; array depth is 2**ADDR_W words.
- LATENCY, 2, cycles from request accept to response valid; legal range 1..15.

Ports:
- clka  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low (rst=0 at a rising edge of clka resets).
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  4  byte write mask; bit i writes byte i (bits 8i+7:8i); 4'b0000 means read.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already byte-lane aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  word at the request address, sampled after any write in the same request.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state == IDLE); it is combinational from state only.
- Reset (rst=0 at an edge):
  - state goes to IDLE; resp_valid=0; resp_rdata=0; latency counter=0.
  - Any in-flight request is aborted. A write whose array update has not yet happened is discarded.
  - Array contents are not cleared by reset.
- IDLE, on edge with req_valid=1:
  - Latch addr, we and wdata.
  - Counter = LATENCY-1.
  - Go to WAIT.
- IDLE, on edge with req_valid=0: stay in IDLE.
- WAIT, counter != 0: decrement the counter.
- WAIT, counter == 0, on that edge:
  - Apply the latched mask to word index = latched addr[ADDR_W+1:2]; unmasked bytes keep their value.
  - resp_rdata = resulting word (new data for written lanes, old data elsewhere).
  - resp_valid=1; go to RESP.
- Latency: for a request accepted at edge N, resp_valid rises after edge N+LATENCY. With LATENCY=1 the access happens at the first edge in WAIT.
- RESP:
  - resp_valid and resp_rdata are held stable until resp_ready=1 at an edge.
  - On that edge: resp_valid=0, go to IDLE; req_ready is 1 in the following cycle.
  - The earliest back-to-back throughput is therefore one request per LATENCY+2 cycles.
- Request inputs are ignored outside IDLE; the core must hold them only until accepted.
- Addressing:
  - Bits above ADDR_W+1 are ignored, so addresses alias (wrap around) modulo 2**(ADDR_W+2) bytes.
  - addr[1:0] is ignored unless the optional feature is compiled in.
- Array read and write share a single port; one access per request.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- With the macro defined, an extra output resp_err (1 bit, reset 0) is added and is valid alongside resp_valid.
- A request is misaligned if:
  - req_we is 4'b1111 or 4'b0000 and addr[1:0] != 0; or
  - req_we is 4'b0011 or 4'b1100 and addr[0] != 0.
- For a misaligned request:
  - The array is not written.
  - resp_rdata = 32'h0, resp_err = 1.
  - Timing and handshake are unchanged.
- Without the macro: no resp_err port; addr[1:0] is ignored; every request performs its access.

Test Plan:
- Reset then write: rst=0 for 2 edges, then rst=1 -> resp_valid=0, req_ready=1. Request we=1111, addr=0x10, wdata=0xDEADBEEF with resp_ready held 1 -> resp_valid high exactly 2 edges after accept, resp_rdata=0xDEADBEEF.
- Byte merge: with 0xDEADBEEF at 0x10, request we=0100, wdata=0x00AA0000 -> resp_rdata=0xDEAABEEF; a following read (we=0000) of 0x10 returns 0xDEAABEEF.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_rdata stable, req_ready=0 throughout, a new req_valid is ignored. Raise resp_ready -> IDLE on the next edge.
- Aliasing: with ADDR_W=10, write 0x11223344 to 0x1004, then read 0x0004 -> 0x11223344.
- Reset mid-op: with LATENCY=4, accept a write to 0x20 of 0x55555555 (old value 0), then assert rst=0 at the second WAIT edge -> resp_valid=0, state IDLE. A later read of 0x20 returns 0x00000000.
- With DMEM_MISALIGN_ERR_EN: we=1111, addr=0x22 -> resp_err=1, resp_rdata=0, array unchanged. With we=0011, addr=0x22 -> resp_err=0 and the write is applied.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the CPU data-memory port. It takes one load/store
// request at a time over a valid/ready request channel. After LATENCY cycles it
// performs a byte-masked write and a word read on an internal word array. The
// result goes back over a valid/ready response channel. With this block in
// place of a zero-wait RAM, the core can be exercised against slow memory.
//
// Parameters:
//   ADDR_W     word-index width; the array holds 2**ADDR_W 32-bit words
//   LATENCY    cycles from request accept to response valid (1..15)
//
// Ports:
//   clka        clock, everything on the rising edge
//   rst         synchronous active-low reset
//   req_valid   core presents a request
//   req_ready   responder is idle and can take a request this cycle
//   req_we      byte write mask, 4'b0000 is a plain read
//   req_addr    byte address (bits above ADDR_W+1 alias)
//   req_wdata   store data, already byte-lane aligned
//   resp_valid  response available
//   resp_ready  core accepts the response
//   resp_rdata  word at the request address after any write of that request
//   resp_err    (only with DMEM_MISALIGN_ERR_EN) misaligned request flag
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   Adds resp_err. Misaligned requests do not touch the array. They return
//   rdata=0 with resp_err=1.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        resp_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              respValid_q, respValid_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       oldWord;
    logic [31:0]       mergedWord;
    logic              memWe;
    logic              unusedAddrBits;

`ifdef DMEM_MISALIGN_ERR_EN
    logic [1:0]        lowAddr_q, lowAddr_d;
    logic              err_q, err_d;
    logic              misaligned;

    assign unusedAddrBits = ^req_addr[31:ADDR_W+2];

    // Full-word and no-mask accesses need word alignment.
    // Half-word masks need half-word alignment.
    assign misaligned = (((we_q == 4'b1111) || (we_q == 4'b0000)) && (lowAddr_q != 2'b00)) ||
                        (((we_q == 4'b0011) || (we_q == 4'b1100)) && lowAddr_q[0]);
    assign resp_err   = err_q;
`else
    assign unusedAddrBits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = respValid_q;
    assign resp_rdata = rdata_q;

    // Read-modify-write of the addressed word. Masked lanes take the store
    // data and the other lanes keep the stored bytes. The same merged word is
    // written back and returned, so a response shows its own write.
    always_comb begin
        oldWord    = mem[idx_q];
        mergedWord = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (we_q[i]) begin
                mergedWord[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Next-state logic. A request is latched only in IDLE. The counter then
    // runs down to zero in WAIT. The array access happens on the edge that
    // leaves WAIT, and the response is held in RESP until the core takes it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        respValid_d = respValid_q;
        rdata_d     = rdata_q;
        memWe       = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        lowAddr_d   = lowAddr_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = req_addr[ADDR_W+1:2];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_START;
                    state_d = WAIT;
`ifdef DMEM_MISALIGN_ERR_EN
                    lowAddr_d = req_addr[1:0];
`endif
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    respValid_d = 1'b1;
                    state_d     = RESP;
`ifdef DMEM_MISALIGN_ERR_EN
                    if (misaligned) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else begin
                        memWe   = 1'b1;
                        rdata_d = mergedWord;
                        err_d   = 1'b0;
                    end
`else
                    memWe   = 1'b1;
                    rdata_d = mergedWord;
`endif
                end
            end
            RESP: begin
                if (resp_ready) begin
                    respValid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers, with a synchronous active-low reset.
    always_ff @(posedge clka) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            we_q        <= 4'd0;
            wdata_q     <= 32'h0;
            respValid_q <= 1'b0;
            rdata_q     <= 32'h0;
`ifdef DMEM_MISALIGN_ERR_EN
            lowAddr_q   <= 2'b00;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            respValid_q <= respValid_d;
            rdata_q     <= rdata_d;
`ifdef DMEM_MISALIGN_ERR_EN
            lowAddr_q   <= lowAddr_d;
            err_q       <= err_d;
`endif
        end
    end

    // Reset does not clear the array. A write whose update edge sees rst low
    // is dropped, so an aborted store never lands.
    always_ff @(posedge clka) begin
        if (rst && memWe) begin
            mem[idx_q] <= mergedWord;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Testbench for dmem_responder (ADDR_W=10, LATENCY=2). Random and directed
// requests are checked against a word-array reference model. The model
// applies the byte-mask, aliasing and (when DMEM_MISALIGN_ERR_EN is defined)
// misalignment rules directly. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int AW  = 10;

    logic        clka = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
`ifdef DMEM_MISALIGN_ERR_EN
    logic        resp_err;
`endif

    logic [31:0] model [0:1023];
    int total = 0;
    int bad   = 0;

    always #5 clka = ~clka;

    dmem_responder #(
        .ADDR_W (AW),
        .LATENCY(LAT)
    ) dut (
        .clka      (clka),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata)
`ifdef DMEM_MISALIGN_ERR_EN
        ,
        .resp_err  (resp_err)
`endif
    );

    // Reference model: one request against a plain word array.
    task automatic modelAccess(input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               output logic [31:0] expRdata, output logic expErr);
        int          idx;
        logic [31:0] word;
        bit          mis;
        idx = int'((addr >> 2) % 1024);
        mis = 0;
`ifdef DMEM_MISALIGN_ERR_EN
        if ((we == 4'hF || we == 4'h0) && (addr % 4) != 0) mis = 1;
        if ((we == 4'h3 || we == 4'hC) && (addr % 2) != 0) mis = 1;
`endif
        if (mis) begin
            expRdata = 32'h0;
            expErr   = 1'b1;
        end else begin
            word = model[idx];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) word[8*b +: 8] = wdata[8*b +: 8];
            end
            model[idx] = word;
            expRdata   = word;
            expErr     = 1'b0;
        end
    endtask

    // Drives one request and collects the response. On entry and exit the
    // bench sits just after a falling edge.
    task automatic applyStimulus(input logic [3:0] we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold,
                                 output logic [31:0] rdata, output logic err,
                                 output int lat, output bit timedOut);
        int guard;
        timedOut = 0;
        lat      = 0;
        err      = 1'b0;
        rdata    = 32'h0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        resp_ready = 1'b0;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 40) begin
            @(posedge clka); @(negedge clka); guard++;
        end
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            timedOut  = 1;
            return;
        end
        @(posedge clka); @(negedge clka);
        req_valid = 1'b0; req_we = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clka); @(negedge clka); lat++;
        end
        if (resp_valid !== 1'b1) begin
            timedOut = 1;
            return;
        end
        repeat (hold) begin
            @(posedge clka); @(negedge clka);
        end
        rdata = resp_rdata;
`ifdef DMEM_MISALIGN_ERR_EN
        err = resp_err;
`endif
        resp_ready = 1'b1;
        @(posedge clka); @(negedge clka);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_we = 4'h0; req_addr = 32'h0;
        req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(posedge clka);
        @(negedge clka);
        rst = 1'b1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        total++;
        if (resp_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", resp_rdata);
        end
`ifdef DMEM_MISALIGN_ERR_EN
        total++;
        if (resp_err !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_err: got %b expected 0", resp_err);
        end
`endif
    endtask

    // Gives the first 64 words known contents so that later reads never see
    // uninitialised storage.
    task automatic test_fill();
        logic [31:0] rd, exp, wd;
        logic        er, expEr;
        int          lat;
        bit          to;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            applyStimulus(4'hF, 32'(i * 4), wd, 0, rd, er, lat, to);
            modelAccess(4'hF, 32'(i * 4), wd, exp, expEr);
            total++;
            if (to || lat != LAT || rd !== exp) begin
                bad++;
                $display("[TB] FAIL fill_%0d: got rdata=%h lat=%0d timeout=%0d expected rdata=%h lat=%0d",
                         i, rd, lat, to, exp, LAT);
            end
        end
    endtask

    // Full-word write, a byte merge, then a read-back of the merged word.
    task automatic test_write_merge();
        logic [3:0]  weT [3]  = '{4'hF, 4'h4, 4'h0};
        logic [31:0] wdT [3]  = '{32'hDEADBEEF, 32'h00AA0000, 32'h0};
        logic [31:0] reqT [3] = '{32'hDEADBEEF, 32'hDEAABEEF, 32'hDEAABEEF};
        logic [31:0] rd, exp;
        logic        er, expEr;
        int          lat;
        bit          to;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(weT[i], 32'h10, wdT[i], 0, rd, er, lat, to);
            modelAccess(weT[i], 32'h10, wdT[i], exp, expEr);
            total++;
            if (to || lat != LAT) begin
                bad++; $display("[TB] FAIL wm_latency_%0d: got %0d (timeout=%0d) expected %0d", i, lat, to, LAT);
            end
            total++;
            if (rd !== reqT[i]) begin
                bad++; $display("[TB] FAIL wm_rdata_%0d: got %h expected %h", i, rd, reqT[i]);
            end
        end
    endtask

    // The response is held under backpressure, and a request presented
    // during that time must be ignored.
    task automatic test_backpressure();
        logic [31:0] wd, exp, rd;
        logic        er, expEr;
        int          guard, lat;
        bit          to;
        wd = $urandom;
        req_valid = 1'b1; req_we = 4'hF; req_addr = 32'h30; req_wdata = wd; resp_ready = 1'b0;
        @(posedge clka); @(negedge clka);
        modelAccess(4'hF, 32'h30, wd, exp, expEr);
        req_we = 4'hF; req_addr = 32'h34; req_wdata = ~wd;
        guard = 0;
        while (resp_valid !== 1'b1 && guard < 40) begin
            @(posedge clka); @(negedge clka); guard++;
        end
        total++;
        if (resp_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_timeout: got resp_valid=%b expected 1", resp_valid);
        end
        for (int c = 0; c < 6; c++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_hold_%0d: got valid=%b rdata=%h ready=%b expected 1 %h 0",
                         c, resp_valid, resp_rdata, req_ready, exp);
            end
            if (c < 5) begin
                @(posedge clka); @(negedge clka);
            end
        end
        resp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clka); @(negedge clka);
        resp_ready = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0 1", resp_valid, req_ready);
        end
        applyStimulus(4'h0, 32'h34, 32'h0, 0, rd, er, lat, to);
        modelAccess(4'h0, 32'h34, 32'h0, exp, expEr);
        total++;
        if (to || rd !== exp) begin
            bad++; $display("[TB] FAIL bp_ignored_req: got %h (timeout=%0d) expected %h", rd, to, exp);
        end
    endtask

    task automatic test_aliasing();
        logic [31:0] rd, exp;
        logic        er, expEr;
        int          lat;
        bit          to;
        applyStimulus(4'hF, 32'h1004, 32'h11223344, 0, rd, er, lat, to);
        modelAccess(4'hF, 32'h1004, 32'h11223344, exp, expEr);
        applyStimulus(4'h0, 32'h0004, 32'h0, 1, rd, er, lat, to);
        modelAccess(4'h0, 32'h0004, 32'h0, exp, expEr);
        total++;
        if (to || rd !== 32'h11223344) begin
            bad++; $display("[TB] FAIL alias_read: got %h (timeout=%0d) expected 11223344", rd, to);
        end
    endtask

    // Reset lands on the edge that would have performed the write.
    task automatic test_reset_midop();
        logic [31:0] rd, exp;
        logic        er, expEr;
        int          lat;
        bit          to;
        applyStimulus(4'hF, 32'h20, 32'h0, 0, rd, er, lat, to);
        modelAccess(4'hF, 32'h20, 32'h0, exp, expEr);
        req_valid = 1'b1; req_we = 4'hF; req_addr = 32'h20; req_wdata = 32'h55555555;
        @(posedge clka); @(negedge clka);
        req_valid = 1'b0;
        @(posedge clka); @(negedge clka);
        rst = 1'b0;
        @(posedge clka); @(negedge clka);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL midop_reset: got valid=%b ready=%b rdata=%h expected 0 1 00000000",
                            resp_valid, req_ready, resp_rdata);
        end
        rst = 1'b1;
        applyStimulus(4'h0, 32'h20, 32'h0, 0, rd, er, lat, to);
        modelAccess(4'h0, 32'h20, 32'h0, exp, expEr);
        total++;
        if (to || rd !== 32'h0) begin
            bad++; $display("[TB] FAIL midop_read: got %h (timeout=%0d) expected 00000000", rd, to);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, wd, addr;
        logic [3:0]  we;
        logic        er, expEr;
        int          lat;
        bit          to;
        for (int i = 0; i < 60; i++) begin
            we   = 4'($urandom);
            wd   = $urandom;
            addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            applyStimulus(we, addr, wd, $urandom_range(0, 2), rd, er, lat, to);
            modelAccess(we, addr, wd, exp, expEr);
            total++;
            if (to || lat != LAT || rd !== exp || er !== expEr) begin
                bad++;
                $display("[TB] FAIL random_%0d: we=%h addr=%h got rdata=%h err=%b lat=%0d timeout=%0d expected %h %b %0d",
                         i, we, addr, rd, er, lat, to, exp, expEr, LAT);
            end
        end
    endtask

    // Requests and responses are both always offered. The responder should
    // then accept one request every LAT+2 cycles.
    task automatic test_back_to_back();
        int accepts = 0;
        int valids  = 0;
        req_valid = 1'b1; req_we = 4'h0; req_addr = 32'h10; req_wdata = 32'h0; resp_ready = 1'b1;
        for (int k = 0; k < 6 * (LAT + 2); k++) begin
            if (req_ready === 1'b1) accepts++;
            if (resp_valid === 1'b1) begin
                valids++;
                total++;
                if (resp_rdata !== model[4]) begin
                    bad++; $display("[TB] FAIL b2b_rdata_%0d: got %h expected %h", k, resp_rdata, model[4]);
                end
            end
            @(posedge clka); @(negedge clka);
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        total++;
        if (accepts != 6 || valids != 6) begin
            bad++; $display("[TB] FAIL b2b_throughput: got accepts=%0d valids=%0d expected 6 6", accepts, valids);
        end
    endtask

`ifdef DMEM_MISALIGN_ERR_EN
    task automatic test_misalign();
        logic [3:0]  weT [3] = '{4'hF, 4'h0, 4'h3};
        logic [31:0] adT [3] = '{32'h22, 32'h20, 32'h22};
        logic        erT [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] rd, exp, wd;
        logic        er, expEr;
        int          lat;
        bit          to;
        for (int i = 0; i < 3; i++) begin
            wd = $urandom;
            applyStimulus(weT[i], adT[i], wd, 0, rd, er, lat, to);
            modelAccess(weT[i], adT[i], wd, exp, expEr);
            total++;
            if (to || er !== erT[i] || rd !== exp) begin
                bad++; $display("[TB] FAIL misalign_%0d: got err=%b rdata=%h expected %b %h", i, er, rd, erT[i], exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_write_merge();
        test_backpressure();
        test_aliasing();
        test_reset_midop();
        test_random();
        test_back_to_back();
`ifdef DMEM_MISALIGN_ERR_EN
        test_misalign();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
